// File: rtl/buzzer_pattern_gen_pkg.sv
// Shared zone/FSM encodings and the distance classifier for the buzzer pattern generator.
package buzzer_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ZONE_NEAR = 2'd0,
        ZONE_MID  = 2'd1,
        ZONE_FAR  = 2'd2
    } zone_t;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_ON     = 2'd1,
        ST_OFF    = 2'd2
    } state_t;

    localparam int PAT_W = 16;

    // Unsigned compare, inclusive at the upper bound of NEAR and MID.
    function automatic zone_t classify(input logic [63:0] v,
                                       input logic [63:0] th_near,
                                       input logic [63:0] th_mid);
        if (v <= th_near)
            return ZONE_NEAR;
        else if (v <= th_mid)
            return ZONE_MID;
        else
            return ZONE_FAR;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/buzzer_pattern_gen_if.sv
// Measurement-in / buzzer-out bundle between the distance block and the pattern generator.
interface buzzer_pattern_gen_if
    import buzzer_pattern_gen_pkg::*;
#(
    parameter int VAL_W = 24
) ();

    logic             enable;
    logic [VAL_W-1:0] value;
    logic             value_valid;
    logic             buzzer;
    zone_t            zone;
    logic             active;

    modport master (
        output enable, value, value_valid,
        input  buzzer, zone, active
    );

    modport slave (
        input  enable, value, value_valid,
        output buzzer, zone, active
    );

endinterface

// File: rtl/buzzer_pattern_gen_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every DIV clocks, restartable through clr.
module ms_tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/buzzer_pattern_gen.sv
// Classifies distance measurements into zones and plays a per-zone beep pattern,
// with a watchdog that forces FAR when measurements stop arriving.
module buzzer_pattern_gen
    import buzzer_pattern_gen_pkg::*;
#(
    parameter int          VAL_W      = 24,
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned TH_NEAR    = 23750,
    parameter int unsigned TH_MID     = 95000,
    parameter int unsigned HALF_NEAR  = 12500,
    parameter int unsigned HALF_MID   = 25000,
    parameter int unsigned ON_NEAR    = 100,
    parameter int unsigned OFF_NEAR   = 0,
    parameter int unsigned ON_MID     = 150,
    parameter int unsigned OFF_MID    = 150,
    parameter int unsigned TIMEOUT_MS = 500
) (
    input logic                 clk,
    input logic                 rst,
    buzzer_pattern_gen_if.slave bus
);

    localparam int unsigned TICK_DIV = CLK_HZ / 1000;
    localparam int unsigned TONE_MAX = max2(HALF_NEAR, HALF_MID);
    localparam int unsigned TONE_W   = (TONE_MAX > 1) ? $clog2(TONE_MAX) : 1;
    localparam bit          WD_EN    = (TIMEOUT_MS != 0);
    localparam int unsigned WD_W     = WD_EN ? $clog2(TIMEOUT_MS + 1) : 1;

    function automatic logic [PAT_W-1:0] on_ms(input zone_t z);
        return (z == ZONE_NEAR) ? PAT_W'(ON_NEAR) : PAT_W'(ON_MID);
    endfunction

    function automatic logic [PAT_W-1:0] off_ms(input zone_t z);
        return (z == ZONE_NEAR) ? PAT_W'(OFF_NEAR) : PAT_W'(OFF_MID);
    endfunction

    function automatic logic [TONE_W-1:0] half_last(input zone_t z);
        return (z == ZONE_NEAR) ? TONE_W'(HALF_NEAR - 1) : TONE_W'(HALF_MID - 1);
    endfunction

    logic [VAL_W-1:0] val_in;
    zone_t            zone_q;
    logic [WD_W-1:0]  wd_cnt;
    logic             stale;
    logic             wd_tick;
    logic             wd_expire;

    assign val_in = bus.value;

    ms_tick_gen #(.DIV(TICK_DIV)) u_wd_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .tick (wd_tick)
    );

    assign wd_expire = WD_EN && wd_tick && !stale && (wd_cnt == WD_W'(TIMEOUT_MS - 1));

    // A fresh measurement outranks a watchdog expiry landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            zone_q <= ZONE_FAR;
            wd_cnt <= '0;
            stale  <= 1'b0;
        end else if (bus.value_valid) begin
            zone_q <= classify(64'(val_in), 64'(TH_NEAR), 64'(TH_MID));
            wd_cnt <= '0;
            stale  <= 1'b0;
        end else if (wd_expire) begin
            zone_q <= ZONE_FAR;
            wd_cnt <= WD_W'(TIMEOUT_MS);
            stale  <= 1'b1;
        end else if (WD_EN && wd_tick && !stale) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    state_t            state;
    logic              buzzer_q;
    logic              active_q;
    logic [PAT_W-1:0]  pat_cnt;
    logic [TONE_W-1:0] tone_cnt;
    logic [TONE_W-1:0] tone_last;
    logic              pat_tick;
    logic              pat_clr;
    logic              go_silent;
    logic              pat_expire;

    assign go_silent  = !bus.enable || (zone_q == ZONE_FAR);
    assign pat_expire = pat_tick && (pat_cnt <= PAT_W'(1));
    // Restarting the prescaler on every ON/OFF entry makes each phase an exact multiple of TICK_DIV.
    assign pat_clr    = go_silent || (state == ST_SILENT) || pat_expire;

    ms_tick_gen #(.DIV(TICK_DIV)) u_pat_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (pat_clr),
        .tick (pat_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SILENT;
            buzzer_q  <= 1'b0;
            active_q  <= 1'b0;
            pat_cnt   <= '0;
            tone_cnt  <= '0;
            tone_last <= '0;
        end else if (go_silent) begin
            state    <= ST_SILENT;
            buzzer_q <= 1'b0;
            active_q <= 1'b0;
            pat_cnt  <= '0;
            tone_cnt <= '0;
        end else begin
            case (state)
                ST_SILENT, ST_OFF: begin
                    if (state == ST_SILENT || pat_expire) begin
                        state     <= ST_ON;
                        buzzer_q  <= 1'b1;
                        active_q  <= 1'b1;
                        pat_cnt   <= on_ms(zone_q);
                        tone_cnt  <= '0;
                        tone_last <= half_last(zone_q);
                    end else if (pat_tick) begin
                        pat_cnt <= pat_cnt - 1'b1;
                    end
                end
                ST_ON: begin
                    if (tone_cnt >= tone_last) begin
                        buzzer_q <= ~buzzer_q;
                        tone_cnt <= '0;
                    end else begin
                        tone_cnt <= tone_cnt + 1'b1;
                    end
                    // Zero off-time means a seamless re-entry: tone phase carries on untouched.
                    if (pat_expire) begin
                        if (off_ms(zone_q) == '0) begin
                            pat_cnt   <= on_ms(zone_q);
                            tone_last <= half_last(zone_q);
                        end else begin
                            state    <= ST_OFF;
                            buzzer_q <= 1'b0;
                            tone_cnt <= '0;
                            pat_cnt  <= off_ms(zone_q);
                        end
                    end else if (pat_tick) begin
                        pat_cnt <= pat_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_SILENT;
                    buzzer_q <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.buzzer = buzzer_q;
    assign bus.zone   = zone_q;
    assign bus.active = active_q;

endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// Self-checking bench for buzzer_pattern_gen: directed scenarios followed by random
// measurements, all compared each cycle against a timestamp-based reference model.
module tb_buzzer_pattern_gen;

    localparam int TICK_DIV   = 10;
    localparam int TH_NEAR    = 23750;
    localparam int TH_MID     = 95000;
    localparam int HALF_NEAR  = 2;
    localparam int HALF_MID   = 4;
    localparam int ON_NEAR    = 5;
    localparam int OFF_NEAR   = 0;
    localparam int ON_MID     = 3;
    localparam int OFF_MID    = 3;
    localparam int TIMEOUT_MS = 20;

    logic  clk;
    logic  rst;
    int    checks;
    int    errors;
    string phase;

    buzzer_pattern_gen_if #(.VAL_W(24)) bus ();

    buzzer_pattern_gen #(
        .VAL_W      (24),
        .CLK_HZ     (10000),
        .TH_NEAR    (TH_NEAR),
        .TH_MID     (TH_MID),
        .HALF_NEAR  (HALF_NEAR),
        .HALF_MID   (HALF_MID),
        .ON_NEAR    (ON_NEAR),
        .OFF_NEAR   (OFF_NEAR),
        .ON_MID     (ON_MID),
        .OFF_MID    (OFF_MID),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edge index since reset, phase end times and tone toggle times.
    int m_k;
    int m_zone;
    int m_ticks;
    int m_mode;
    int m_seg_end;
    int m_half;
    int m_last;
    int m_buz;

    function automatic int zone_of(input int v);
        if (v <= TH_NEAR) return 0;
        if (v <= TH_MID)  return 1;
        return 2;
    endfunction

    function automatic int on_of(input int z);
        return (z == 0) ? ON_NEAR : ON_MID;
    endfunction

    function automatic int off_of(input int z);
        return (z == 0) ? OFF_NEAR : OFF_MID;
    endfunction

    function automatic int half_of(input int z);
        return (z == 0) ? HALF_NEAR : HALF_MID;
    endfunction

    task automatic model_reset();
        m_k = 0; m_zone = 2; m_ticks = 0; m_mode = 0;
        m_seg_end = 0; m_half = 1; m_last = 0; m_buz = 0;
    endtask

    task automatic model_step(input logic en, input logic vv, input int val);
        m_k++;
        if (!en || m_zone == 2) begin
            m_mode = 0;
            m_buz  = 0;
        end else if (m_mode == 0 || (m_mode == 2 && m_k == m_seg_end)) begin
            m_mode    = 1;
            m_buz     = 1;
            m_last    = m_k;
            m_half    = half_of(m_zone);
            m_seg_end = m_k + TICK_DIV * on_of(m_zone);
        end else if (m_mode == 1) begin
            if (m_k - m_last >= m_half) begin
                m_buz  = 1 - m_buz;
                m_last = m_k;
            end
            if (m_k == m_seg_end) begin
                if (off_of(m_zone) == 0) begin
                    m_seg_end = m_k + TICK_DIV * on_of(m_zone);
                    m_half    = half_of(m_zone);
                end else begin
                    m_mode    = 2;
                    m_buz     = 0;
                    m_seg_end = m_k + TICK_DIV * off_of(m_zone);
                end
            end
        end
        if (vv) begin
            m_zone  = zone_of(val);
            m_ticks = 0;
        end else if (m_k % TICK_DIV == 0) begin
            m_ticks++;
            if (m_ticks == TIMEOUT_MS) m_zone = 2;
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s/%s observed=%0d expected=%0d (edge %0d)", phase, tag, obs, exp, m_k);
            $error("[TB] %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check_value("buzzer", 32'(bus.buzzer), 32'(m_buz));
        check_value("zone",   32'(bus.zone),   32'(m_zone));
        check_value("active", 32'(bus.active), (m_mode != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic vv, input logic [23:0] val);
        @(negedge clk);
        rst             = r;
        bus.enable      = en;
        bus.value_valid = vv;
        bus.value       = val;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(en, vv, int'(val));
        #1;
        checkOutput();
    endtask

    initial begin
        logic        en;
        logic        vv;
        int unsigned sel;
        int unsigned rv;
        int          target;
        int unsigned edge_vals [4];

        edge_vals = '{23750, 23751, 95000, 95001};
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.value_valid = 1'b0;
        bus.value = '0;
        model_reset();

        phase = "reset";
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'(i % 2 == 0), 24'd100);
            check_value("rst_buzzer", 32'(bus.buzzer), 32'd0);
            check_value("rst_zone",   32'(bus.zone),   32'd2);
            check_value("rst_active", 32'(bus.active), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);

        phase = "near";
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd100);
        check_value("latency_zone", 32'(bus.zone), 32'd0);
        check_value("latency_idle", 32'(bus.buzzer), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);
        check_value("latency_buzzer", 32'(bus.buzzer), 32'd1);
        check_value("latency_active", 32'(bus.active), 32'd1);
        for (int i = 0; i < 150; i++)
            applyStimulus(1'b0, 1'b1, 1'(i % 50 == 49), 24'd100);

        phase = "mid";
        applyStimulus(1'b0, 1'b0, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'd50000);
        for (int i = 0; i < 200; i++)
            applyStimulus(1'b0, 1'b1, 1'(i % 50 == 49), 24'd50000);

        phase = "bound";
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd23750);
        check_value("b23750", 32'(bus.zone), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd23751);
        check_value("b23751", 32'(bus.zone), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd95000);
        check_value("b95000", 32'(bus.zone), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd95001);
        check_value("b95001", 32'(bus.zone), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);
        check_value("far_buzzer", 32'(bus.buzzer), 32'd0);
        check_value("far_active", 32'(bus.active), 32'd0);

        phase = "abort";
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd50000);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd200000);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);
        check_value("far_buzzer", 32'(bus.buzzer), 32'd0);
        check_value("far_active", 32'(bus.active), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd50000);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'd0);
        check_value("mute_buzzer", 32'(bus.buzzer), 32'd0);
        check_value("mute_active", 32'(bus.active), 32'd0);

        phase = "watchdog";
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd100);
        for (int i = 0; i < 215; i++) applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);
        check_value("stale_zone",   32'(bus.zone),   32'd2);
        check_value("stale_active", 32'(bus.active), 32'd0);
        check_value("stale_buzzer", 32'(bus.buzzer), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd100);
        target = ((m_k / TICK_DIV) + 1) * TICK_DIV + (TIMEOUT_MS - 1) * TICK_DIV;
        for (int i = 0; i < 400 && m_k + 1 < target; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 24'd100);
        check_value("race_zone", 32'(bus.zone), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 24'd0);
        check_value("race_active", 32'(bus.active), 32'd1);

        phase = "random";
        en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) en = !en;
            vv  = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 4)       rv = $urandom_range(0, 23750);
            else if (sel < 7)  rv = $urandom_range(23751, 95000);
            else if (sel < 8)  rv = $urandom_range(95001, 200000);
            else               rv = edge_vals[$urandom_range(0, 3)];
            applyStimulus(1'b0, en, vv, 24'(rv));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
